zx_bus_dma_loader: RTL
======================

Name: zx_bus_dma_loader

Overview:
- Parametrised hardware bus-master loader for the Z80 side of the ZX core.
- Replaces soft-CPU byte-banging of BUSREQ/address/data PIO ports.
- Accepts a transfer descriptor (start address, length) plus a byte stream from the SD loader.
- Requests the Z80 bus, writes the bytes into Z80 memory with programmable strobe timing, then releases the bus and reports completion or timeout.

Parameters:
- ADDR_W, 16, Z80 address width; also the length-counter width.
- DATA_W, 8, data bus and stream width.
- FIFO_DEPTH, 16, internal byte FIFO entries; power of two, at least 2.
- SETUP_CYCLES, 1, clocks that address/data/mreq_n are valid before wr_n falls (at least 1).
- WR_CYCLES, 4, clocks wr_n is held low (at least 1).
- ACK_TIMEOUT, 1023, maximum clocks to wait for the synchronised bus_ack_n low.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse; ignored while busy.
- cfg_addr  in  ADDR_W  first target address, sampled on cfg_start.
- cfg_len  in  ADDR_W  byte count, sampled on cfg_start.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  stream accept; a byte transfers when in_valid and in_ready are both high.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err_timeout  out  1  sticky; cleared by the next accepted cfg_start.
- bus_req_n  out  1  Z80 BUSREQ.
- bus_ack_n  in  1  Z80 BUSACK; asynchronous, so it is double-flop synchronised.
- addr_out  out  ADDR_W  Z80 address.
- data_out  out  DATA_W  Z80 data.
- data_oe  out  1  data tristate enable.
- mreq_n  out  1  memory request strobe.
- wr_n  out  1  write strobe.

Behaviour:
- Reset values:
  - bus_req_n, mreq_n, wr_n = 1.
  - data_oe, busy, done, err_timeout, in_ready = 0.
  - addr_out, data_out = 0.
  - FIFO flushed; FSM in IDLE.
- Reset mid-transfer: all outputs return to reset values on the next edge, releasing the bus immediately.
- in_ready = busy AND FIFO not full AND accepted-count < cfg_len. The block never accepts bytes beyond the programmed length.
- FSM states: IDLE, REQ, SETUP, STROBE, HOLD, RELEASE.
- IDLE:
  - On cfg_start with cfg_len = 0: done pulses on the next cycle; the bus is never requested; busy stays 0.
  - On cfg_start with cfg_len ≠ 0: latch address and length, clear err_timeout, set busy, go to REQ.
- REQ:
  - bus_req_n = 0.
  - When the synchronised bus_ack_n = 0, go to SETUP.
  - If ACK_TIMEOUT clocks elapse first: bus_req_n = 1, err_timeout = 1, flush the FIFO, pulse done, clear busy, go to IDLE.
- SETUP:
  - Wait while the FIFO is empty; the bus stays held, mreq_n = 1, data_oe = 0.
  - With a byte available: pop it into data_out, drive addr_out, data_oe = 1, mreq_n = 0.
  - After SETUP_CYCLES such clocks, go to STROBE.
- STROBE: wr_n = 0 for exactly WR_CYCLES clocks, then go to HOLD.
- HOLD (one clock):
  - wr_n = 1, mreq_n = 1; data and address are still driven.
  - Then address increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and remaining length decrements.
  - If remaining length = 0, go to RELEASE; otherwise go to SETUP.
- RELEASE:
  - data_oe = 0, bus_req_n = 1.
  - Wait for the synchronised bus_ack_n = 1, then pulse done, clear busy, go to IDLE.
  - No timeout in this state.
- Minimum per-byte period: SETUP_CYCLES + WR_CYCLES + 1 clocks.
- A cfg_start that arrives in the same cycle as done is ignored.
- The FIFO is a standard circular buffer. A simultaneous push and pop keeps the count unchanged; a push when full cannot happen because in_ready is low.

Optional Feature:
- Macro: ZX_DMA_CHECKSUM_EN.
- With the macro defined:
  - Extra output port checksum [15:0] = 16-bit wrapping sum of every byte written, zero-extended.
  - Cleared on an accepted cfg_start; updated in HOLD.
  - Stable once done pulses.
- Without the macro: the port and the adder are absent.

Decomposition:
- Package zx_dma_pkg holds:
  - FSM state enum.
  - Default timing constants.
  - Helper function clog2_depth for pointer widths.
- One sub-module: zx_dma_fifo (parametrised DATA_W/FIFO_DEPTH synchronous FIFO with push, pop, full, empty).
- The synchroniser stays inline.

Test Plan:
- Basic write: cfg_addr = 0x4000, cfg_len = 3, bytes 0xAA, 0x55, 0x0F; bus_ack_n falls 5 clocks after bus_req_n.
  - Expect exactly three wr_n pulses, each WR_CYCLES = 4 clocks long, at addresses 0x4000–0x4002 carrying those bytes.
  - Then bus_req_n = 1 and done pulses after bus_ack_n returns high.
- Address wrap: cfg_addr = 0xFFFE, cfg_len = 4.
  - Expect writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Timeout: bus_ack_n held high.
  - Expect bus_req_n to go high after 1023 clocks, err_timeout = 1, and done to pulse with no wr_n activity.
  - A later cfg_start clears err_timeout.
- Stream starvation: cfg_len = 2, second byte delayed 20 clocks.
  - Expect the bus to stay held (bus_req_n = 0), mreq_n = 1, data_oe = 0 during the gap, then the second write completes normally.
- Zero length and busy start: cfg_len = 0 → done pulses on the next cycle with bus_req_n never low.
  - A cfg_start during an active transfer is ignored; cfg_addr/cfg_len stay unchanged.
- Reset mid-STROBE: assert reset_reset while wr_n = 0.
  - Expect wr_n, mreq_n, bus_req_n = 1 and data_oe = 0 on the next edge.
  - With ZX_DMA_CHECKSUM_EN, writing 0xFF, 0x02 gives checksum 0x0101.

Source files
------------

// File: rtl/zx_dma_pkg.sv
// Shared types and constants for the ZX Z80 bus-master DMA loader.
// Holds the FSM states, default timing and pointer-width helper.
package zx_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE
  } dma_state_e;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 16;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_WR_CYCLES    = 4;
  localparam int DEF_ACK_TIMEOUT  = 1023;

  localparam int CNT_W = 16;

  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/zx_dma_fifo.sv
// Circular byte FIFO between the SD stream and the Z80 write engine.
// Read data is the current head entry (first-word fall-through).
module zx_dma_fifo
  import zx_dma_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = clog2_depth(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // pointer and occupancy update
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_q];
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);

endmodule

// File: rtl/zx_bus_dma_loader.sv
// Z80 bus-master loader: BUSREQ, strobed memory writes, BUSREQ release.
// Optional checksum output enabled by defining ZX_DMA_CHECKSUM_EN.
module zx_bus_dma_loader
  import zx_dma_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int WR_CYCLES    = DEF_WR_CYCLES,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              mreq_n,
  output logic              wr_n
`ifdef ZX_DMA_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  dma_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_s1_q, ack_s2_q;

  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;

`ifdef ZX_DMA_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;
`endif

  zx_dma_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .flush     (flush),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy     = (state_q != S_IDLE);
  assign in_ready = busy && !fifo_full && (acc_q != '0);
  assign push     = in_valid && in_ready;

  // transfer sequencing: next state and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = err_q;
    pop      = 1'b0;
    flush    = 1'b0;
`ifdef ZX_DMA_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    if (push) acc_d = acc_q - ADDR_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start && !done_q) begin
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = cfg_addr;
            rem_d    = cfg_len;
            acc_d    = cfg_len;
            err_d    = 1'b0;
            cnt_d    = '0;
            loaded_d = 1'b0;
            state_d  = S_REQ;
`ifdef ZX_DMA_CHECKSUM_EN
            chk_d    = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (!ack_s2_q) begin
          cnt_d   = '0;
          state_d = S_SETUP;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (!loaded_q) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            data_d   = fifo_data;
            loaded_d = 1'b1;
            cnt_d    = '0;
          end
        end else if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - ADDR_W'(1);
        cnt_d  = '0;
`ifdef ZX_DMA_CHECKSUM_EN
        chk_d  = chk_q + 16'(data_q);
`endif
        if (rem_q == ADDR_W'(1)) begin
          loaded_d = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          state_d  = S_SETUP;
          loaded_d = !fifo_empty;
          if (!fifo_empty) begin
            pop    = 1'b1;
            data_d = fifo_data;
          end
        end
      end
      S_RELEASE: begin
        if (ack_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, datapath and BUSACK synchroniser registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_s1_q <= 1'b1;
      ack_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ack_s1_q <= bus_ack_n;
      ack_s2_q <= ack_s1_q;
    end
  end

`ifdef ZX_DMA_CHECKSUM_EN
  // running sum of written bytes
  always_ff @(posedge clk_clk) begin
    if (reset_reset) chk_q <= '0;
    else             chk_q <= chk_d;
  end
  assign checksum = chk_q;
`endif

  assign bus_req_n   = !(state_q == S_REQ || state_q == S_SETUP ||
                         state_q == S_STROBE || state_q == S_HOLD);
  assign mreq_n      = !((state_q == S_SETUP && loaded_q) ||
                         state_q == S_STROBE);
  assign wr_n        = (state_q != S_STROBE);
  assign data_oe     = (state_q == S_SETUP && loaded_q) ||
                       state_q == S_STROBE || state_q == S_HOLD;
  assign addr_out    = addr_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule
